debounce_evt: RTL and testbench

- Single-channel input conditioner placed directly upstream of the library's combinational gates (NOR2X1 class): raw, asynchronous, possibly bouncing pad signals in; clean glitch-free levels out for the gate-level logic.
- Stages: 2-flop synchronizer, then debounce state machine with consecutive-sample counter.
- Emits one-cycle RISE/FALL pulses.
- Holds a level-valid event with ACK handshake and a sticky overrun flag for a polling controller.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_evt_if.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/debounce_evt.sv | 114 +++++++++++
 tb/tb_debounce_evt.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the debounce/event conditioner.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } db_state_e;

    localparam int DB_CYCLES_MIN = 1;
    localparam int DB_CYCLES_MAX = 255;

    // Counter must be able to hold DB_CYCLES itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit db_cycles_ok(input int n);
        return (n >= DB_CYCLES_MIN) && (n <= DB_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/debounce_evt_if.sv
// Pad-side and consumer-side signals of one debounce channel.
interface debounce_evt_if;
    logic A;
    logic Y;
    logic RISE;
    logic FALL;
    logic EVT_VALID;
    logic EVT_DIR;
    logic EVT_ACK;
    logic OVERRUN;
    logic OVR_CLR;

    modport master (
        output A, EVT_ACK, OVR_CLR,
        input  Y, RISE, FALL, EVT_VALID, EVT_DIR, OVERRUN
    );

    modport slave (
        input  A, EVT_ACK, OVR_CLR,
        output Y, RISE, FALL, EVT_VALID, EVT_DIR, OVERRUN
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs, reset to a chosen level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/debounce_evt.sv
// Debounced level with one-cycle edge pulses, an ACK'd edge event and a
// sticky overrun flag. Every output is a flop.
module debounce_evt
    import debounce_pkg::*;
#(
    parameter int   DB_CYCLES = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic          CLK,
    input  logic          R,
    debounce_evt_if.slave bus
);
    localparam int              CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (!db_cycles_ok(DB_CYCLES)) begin : g_bad_db_cycles
        $error("debounce_evt: DB_CYCLES out of range 1..255");
    end

    logic             sync2;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_dir_q, evt_dir_d;
    logic             overrun_q, overrun_d;
    logic             flip;

    sync_2ff #(.RST_VAL(RESET_VAL)) u_sync (
        .clk   (CLK),
        .rst_n (R),
        .d     (bus.A),
        .q     (sync2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2 != y_q) begin
                    if (DB_CYCLES == 1) begin
                        flip = 1'b1;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                if (sync2 == y_q) begin
                    // Bounce back: the count restarts from scratch.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    flip    = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        y_d    = flip ? ~y_q : y_q;
        rise_d = flip & ~y_q;
        fall_d = flip & y_q;
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_dir_d   = evt_dir_q;
        overrun_d   = overrun_q & ~bus.OVR_CLR;
        if (flip) begin
            evt_valid_d = 1'b1;
            evt_dir_d   = y_d;
            // An edge landing on an unconsumed event wins over OVR_CLR.
            if (evt_valid_q && !bus.EVT_ACK) overrun_d = 1'b1;
        end else if (bus.EVT_ACK) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q     <= STABLE;
            cnt_q       <= '0;
            y_q         <= RESET_VAL;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_dir_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            evt_valid_q <= evt_valid_d;
            evt_dir_q   <= evt_dir_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.Y         = y_q;
    assign bus.RISE      = rise_q;
    assign bus.FALL      = fall_q;
    assign bus.EVT_VALID = evt_valid_q;
    assign bus.EVT_DIR   = evt_dir_q;
    assign bus.OVERRUN   = overrun_q;
endmodule

// File: tb/tb_debounce_evt.sv
// Directed bench: DB_CYCLES=4 and DB_CYCLES=1 channels sharing clock and reset.
module tb_debounce_evt;
    logic CLK = 1'b0;
    logic R;

    debounce_evt_if if4();
    debounce_evt_if if1();

    debounce_evt #(.DB_CYCLES(4), .RESET_VAL(1'b0)) u_db4 (
        .CLK (CLK),
        .R   (R),
        .bus (if4.slave)
    );

    debounce_evt #(.DB_CYCLES(1), .RESET_VAL(1'b0)) u_db1 (
        .CLK (CLK),
        .R   (R),
        .bus (if1.slave)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // {Y, RISE, FALL, EVT_VALID, EVT_DIR, OVERRUN}
    function automatic logic [5:0] st4();
        return {if4.Y, if4.RISE, if4.FALL, if4.EVT_VALID, if4.EVT_DIR, if4.OVERRUN};
    endfunction

    // {Y, RISE, FALL, EVT_VALID, EVT_DIR}
    function automatic logic [4:0] st1();
        return {if1.Y, if1.RISE, if1.FALL, if1.EVT_VALID, if1.EVT_DIR};
    endfunction

    initial begin
        R = 1'b0;
        if4.A = 1'b1; if4.EVT_ACK = 1'b0; if4.OVR_CLR = 1'b0;
        if1.A = 1'b1; if1.EVT_ACK = 1'b0; if1.OVR_CLR = 1'b0;

        // Reset held with A high: nothing may move.
        tick(3);
        check("rst_db4", 8'(st4()), 8'b000000);
        check("rst_db1", 8'(st1()), 8'b00000);
        if4.A = 1'b0;
        if1.A = 1'b0;
        R = 1'b1;
        tick(1);
        check("rel_db4", 8'(st4()), 8'b000000);

        // Bounce: high 3, low 1, then steady high; rise 5 edges after steady.
        if4.A = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            if (e == 3) if4.A = 1'b0;
            if (e == 4) if4.A = 1'b1;
            check("bnc_hold", 8'({if4.Y, if4.RISE}), 8'b00);
        end
        tick(1);
        check("bnc_rise", 8'(st4()), 8'b110110);
        tick(1);
        check("bnc_pulse1", 8'(st4()), 8'b100110);

        // ACK clears the event; a second ACK with nothing pending is ignored.
        if4.EVT_ACK = 1'b1; tick(1); if4.EVT_ACK = 1'b0;
        check("ack_clr", 8'(st4()), 8'b100010);
        if4.EVT_ACK = 1'b1; tick(1); if4.EVT_ACK = 1'b0;
        check("ack_idle", 8'(st4()), 8'b100010);

        // Clean fall.
        if4.A = 1'b0;
        tick(5);
        check("fall_hold", 8'(st4()), 8'b100010);
        tick(1);
        check("fall", 8'(st4()), 8'b001100);
        tick(1);
        check("fall_pulse1", 8'(st4()), 8'b000100);

        // Rise with the fall event still pending -> overrun.
        if4.A = 1'b1;
        tick(5);
        check("ovr_hold", 8'(st4()), 8'b000100);
        tick(1);
        check("ovr_rise", 8'(st4()), 8'b110111);

        // Fall, still no ACK.
        if4.A = 1'b0;
        tick(6);
        check("ovr_fall", 8'(st4()), 8'b001101);

        // OVR_CLR coincident with an edge keeps OVERRUN; alone it clears.
        if4.A = 1'b1;
        tick(5);
        if4.OVR_CLR = 1'b1;
        tick(1);
        check("clr_vs_set", 8'(st4()), 8'b110111);
        tick(1);
        if4.OVR_CLR = 1'b0;
        check("clr_alone", 8'(st4()), 8'b100110);

        // ACK on the same edge as a flip: event re-armed, no overrun.
        if4.A = 1'b0;
        tick(5);
        if4.EVT_ACK = 1'b1;
        tick(1);
        if4.EVT_ACK = 1'b0;
        check("ack_with_flip", 8'(st4()), 8'b001100);
        tick(1);
        check("ack_flip_next", 8'(st4()), 8'b000100);

        // DB_CYCLES=1: Y follows at edge k+2.
        if1.A = 1'b1;
        tick(2);
        check("db1_hold", 8'(st1()), 8'b00000);
        tick(1);
        check("db1_rise", 8'(st1()), 8'b11011);
        tick(1);
        check("db1_pulse1", 8'(st1()), 8'b10011);
        if1.A = 1'b0;
        tick(2);
        check("db1_fhold", 8'(st1()), 8'b10011);
        tick(1);
        check("db1_fall", 8'(st1()), 8'b00110);
        tick(1);
        check("db1_fpulse1", 8'(st1()), 8'b00010);

        // Reset asserted mid-CHECK: immediate clear, no pulse, count restarts.
        if4.A = 1'b1;
        tick(6);
        check("pre_rst_rise", 8'(st4()), 8'b110111);
        if4.A = 1'b0;
        tick(4);
        check("mid_check", 8'(st4()), 8'b100111);
        #2;
        R = 1'b0;
        #1;
        check("rst_async", 8'(st4()), 8'b000000);
        if4.A = 1'b1;
        tick(2);
        check("rst_held", 8'(st4()), 8'b000000);
        R = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            check("post_rst_hold", 8'({if4.Y, if4.RISE, if4.FALL}), 8'b000);
        end
        tick(1);
        check("post_rst_rise", 8'(st4()), 8'b110110);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
